// File: rtl/data_sram_bridge_pkg.sv
// Shared types and constants for the data SRAM bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_sram_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Bus transfer size codes.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Byte-write-enable patterns produced by the MEM stage.
  localparam logic [3:0] WEN_READ = 4'b0000;
  localparam logic [3:0] WEN_B0   = 4'b0001;
  localparam logic [3:0] WEN_B1   = 4'b0010;
  localparam logic [3:0] WEN_B2   = 4'b0100;
  localparam logic [3:0] WEN_B3   = 4'b1000;
  localparam logic [3:0] WEN_H0   = 4'b0011;
  localparam logic [3:0] WEN_H1   = 4'b1100;
  localparam logic [3:0] WEN_WORD = 4'b1111;

endpackage

// File: rtl/data_req_encode.sv
// Maps MEM-stage byte enables and address onto bus size/aligned address/write flag.
// Latency: purely combinational.
// Backpressure: none; no state.
// Ports: wen/addr in; wr, size, addr_aligned out.
module data_req_encode
  import data_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] addr,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr_aligned
);

  always_comb begin
    wr           = |wen;
    size         = SZ_WORD;
    addr_aligned = addr;
    case (wen)
      WEN_READ: addr_aligned = {addr[ADDR_W-1:2], 2'b00};
      WEN_B0, WEN_B1, WEN_B2, WEN_B3: size = SZ_BYTE;
      WEN_H0, WEN_H1: begin
        size         = SZ_HALF;
        addr_aligned = {addr[ADDR_W-1:1], 1'b0};
      end
      WEN_WORD: addr_aligned = {addr[ADDR_W-1:2], 2'b00};
      // Patterns the MEM stage never produces: word size, address untouched.
      default: ;
    endcase
  end

endmodule

// File: rtl/data_sram_bridge.sv
// Bridges the MEM-stage single-cycle data_sram strobe onto a req/addr_ok/data_ok bus.
// Latency: en at cycle 0, request at cycle 1, earliest completion (stall released) at cycle 2.
// Backpressure: mem_busy stalls the pipeline until the access completes; one outstanding access.
// Ports: data_sram_* (MEM side), mem_busy/pipe_hold/flush (pipeline control),
//        data_* (split-transaction bus), clk and async active-low rst.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              mem_busy,
  input  logic              pipe_hold,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  state_t              state_q, state_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                enc_wr;
  logic [1:0]          enc_size;
  logic [ADDR_W-1:0]   enc_addr;
  logic                proto_err;

  data_req_encode #(.ADDR_W(ADDR_W)) u_enc (
    .wen          (data_sram_wen),
    .addr         (data_sram_addr),
    .wr           (enc_wr),
    .size         (enc_size),
    .addr_aligned (enc_addr)
  );

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_busy  = 1'b0;
    proto_err = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mem_busy  = data_sram_en && !flush;
        proto_err = data_data_ok;
        if (data_sram_en && !flush) begin
          wr_d    = enc_wr;
          size_d  = enc_size;
          addr_d  = enc_addr;
          wdata_d = data_sram_wdata;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        mem_busy = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            // Completed in one cycle; a flushed instruction must not see its data.
            if (flush) begin
              state_d = ST_IDLE;
            end else begin
              if (!wr_q) rdata_d = data_rdata;
              state_d = ST_DONE;
            end
          end else begin
            // Accepted by the slave, so a flush must still wait out the response.
            state_d = flush ? ST_DRAIN : ST_WAIT;
          end
        end else begin
          proto_err = data_data_ok;
          if (flush) state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        mem_busy = 1'b1;
        if (data_data_ok) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            if (!wr_q) rdata_d = data_rdata;
            state_d = ST_DONE;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // The flushed access no longer stalls the pipe; only a new one does.
        mem_busy = data_sram_en;
        if (data_data_ok) state_d = ST_IDLE;
      end

      ST_DONE: begin
        proto_err = data_data_ok;
        // While frozen, the stage still presents the same access: do not reissue it.
        if (flush || !pipe_hold) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // A response with no accepted request outstanding is ignored by the FSM.
  always_ff @(posedge clk) begin
    if (rst) assert (!proto_err);
  end

  assign data_req        = (state_q == ST_REQ);
  assign data_wr         = wr_q;
  assign data_size       = size_q;
  assign data_addr       = addr_q;
  assign data_wdata      = wdata_q;
  assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'd0;
  logic [31:0] data_sram_addr = '0;
  logic [31:0] data_sram_wdata = '0;
  logic [31:0] data_sram_rdata;
  logic        mem_busy;
  logic        pipe_hold = 1'b0;
  logic        flush = 1'b0;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] model_rdata = '0;

  always #5 clk = ~clk;

  data_sram_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .mem_busy        (mem_busy),
    .pipe_hold       (pipe_hold),
    .flush           (flush),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference: size follows the number of enabled lanes, address aligned to that size.
  function automatic void model_req(input logic [3:0] wen, input logic [31:0] a,
                                    output logic wr, output logic [1:0] sz,
                                    output logic [31:0] ba);
    int n;
    n  = $countones(wen);
    wr = (n != 0);
    if (n == 0 || n == 4) begin
      sz = 2'd2; ba = a & ~32'd3;
    end else if (n == 2) begin
      sz = 2'd1; ba = a & ~32'd1;
    end else begin
      sz = 2'd0; ba = a;
    end
  endfunction

  task automatic check_zero(input string pfx);
    check({pfx, "_req"},   data_req, 0);
    check({pfx, "_wr"},    data_wr, 0);
    check({pfx, "_busy"},  mem_busy, 0);
    check({pfx, "_size"},  data_size, 0);
    check({pfx, "_addr"},  data_addr, 0);
    check({pfx, "_wdata"}, data_wdata, 0);
    check({pfx, "_rdata"}, data_sram_rdata, 0);
  endtask

  // One MEM-stage access served by a slave with a_dly extra request cycles before
  // addr_ok and d_dly cycles from addr_ok to data_ok; hold = frozen cycles in DONE.
  task automatic run_access(input logic [3:0] wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rd,
                            input int a_dly, input int d_dly, input int hold);
    logic        exp_wr;
    logic [1:0]  exp_sz;
    logic [31:0] exp_a, exp_rd;
    int busy_cnt = 0, req_cnt = 0, wcnt = 0, resp_k = -1, hold_left = hold;
    bit accepted = 0, fin = 0, stable = 1, rd_ok = 1;
    model_req(wen, addr, exp_wr, exp_sz, exp_a);
    exp_rd = exp_wr ? model_rdata : rd;

    @(negedge clk);
    data_sram_en = 1'b1; data_sram_wen = wen; data_sram_addr = addr; data_sram_wdata = wdata;
    #1 if (mem_busy) busy_cnt++;

    for (int k = 1; k < 100 && !fin; k++) begin
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b0; pipe_hold = 1'b0;
      data_rdata = $urandom;
      if (resp_k >= 0 && k > resp_k) begin
        pipe_hold = (hold_left > 0);
        if (hold_left > 0) hold_left--;
        if (data_req) req_cnt++;
        rd_ok &= (data_sram_rdata === exp_rd);
        if (!pipe_hold) fin = 1;
      end else if (data_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check("wr", data_wr, exp_wr);
          check("size", data_size, exp_sz);
          check("addr", data_addr, exp_a);
          if (exp_wr) check("wdata", data_wdata, wdata);
        end else begin
          stable &= (data_wr === exp_wr) && (data_size === exp_sz) && (data_addr === exp_a)
                    && (!exp_wr || data_wdata === wdata);
        end
        if (req_cnt > a_dly) begin
          data_addr_ok = 1'b1; accepted = 1;
          if (d_dly == 0) begin data_data_ok = 1'b1; data_rdata = rd; resp_k = k; end
        end
      end else if (accepted) begin
        wcnt++;
        if (wcnt >= d_dly) begin data_data_ok = 1'b1; data_rdata = rd; resp_k = k; end
      end
      #1 if (mem_busy) busy_cnt++;
    end

    check("timeout", fin, 1);
    check("rdata", data_sram_rdata, exp_rd);
    check("rdata_held", rd_ok, 1);
    check("stable", stable, 1);
    check("busy_cycles", busy_cnt, 2 + a_dly + d_dly);
    check("req_cycles", req_cnt, 1 + a_dly);

    @(negedge clk);
    data_sram_en = 1'b0; data_sram_wen = 4'd0; pipe_hold = 1'b0;
    #1 check("idle_req", data_req, 0);
    if (!exp_wr) model_rdata = rd;
  endtask

  logic [3:0] legal_wen [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                4'b1000, 4'b0011, 4'b1100, 4'b1111};
  int req_seen;

  initial begin
    #2 check_zero("rst0");
    @(negedge clk) rst = 1'b1;

    // Directed cases
    run_access(4'b0000, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    run_access(4'b0100, 32'h0000_2002, 32'h00AB_0000, 32'h0, 1, 2, 0);
    run_access(4'b0000, 32'h0000_3006, 32'h0, 32'h1234_5678, 3, 4, 0);
    run_access(4'b0000, 32'h0000_4008, 32'h0, 32'hCAFE_F00D, 0, 1, 3);

    // Flush in REQ before addr_ok: request withdrawn.
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h5000;
    @(negedge clk);
    check("frq_req", data_req, 1);
    flush = 1'b1; data_sram_en = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1 check("frq_withdrawn", data_req, 0);
    check("frq_busy", mem_busy, 0);
    req_seen = 0;
    repeat (3) begin
      @(negedge clk);
      #1 if (data_req) req_seen++;
    end
    check("frq_no_reissue", req_seen, 0);

    // Flush in WAIT, new read while draining.
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h6000;
    @(negedge clk);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; flush = 1'b1; data_sram_en = 1'b0;
    #1 check("drn_wait_busy", mem_busy, 1);
    @(negedge clk);
    flush = 1'b0; data_sram_en = 1'b1; data_sram_addr = 32'h7003;
    #1 check("drn_new_busy", mem_busy, 1);
    check("drn_no_req", data_req, 0);
    @(negedge clk);
    data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
    #1 check("drn_no_req2", data_req, 0);
    @(negedge clk);
    data_data_ok = 1'b0;
    #1 check("drn_idle_busy", mem_busy, 1);
    check("drn_rdata_kept", data_sram_rdata, model_rdata);
    @(negedge clk);
    check("drn_new_req", data_req, 1);
    check("drn_new_addr", data_addr, 32'h7000);
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h7777_0001;
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1 check("drn_done_busy", mem_busy, 0);
    check("drn_done_rdata", data_sram_rdata, 32'h7777_0001);
    model_rdata = 32'h7777_0001;
    @(negedge clk);
    data_sram_en = 1'b0;

    // Randomized accesses
    for (int i = 0; i < 20; i++) begin
      run_access(legal_wen[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset in the middle of WAIT
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_wen = 4'b1111; data_sram_addr = 32'h8004;
    data_sram_wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; data_sram_en = 1'b0; data_sram_wen = 4'd0;
    #1 rst = 1'b0;
    #1 check_zero("rstw");
    @(negedge clk) rst = 1'b1;
    model_rdata = '0;
    run_access(4'b0011, 32'h0000_9003, 32'h0000_BEEF, 32'h0, 0, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
